// File: rtl/inst_issuer.sv
// Instruction sequencer: loads a byte-serial program, issues it to the ALU core, collects results.
// Optional WAIT-state result timeout enabled by defining ISSUER_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | accept program bytes, clear, or start
// ISSUE  | inst_valid high, waiting for inst_ready
// WAIT   | waiting for res_valid from the core
// DONE   | one-cycle done pulse, back to IDLE
module inst_issuer #(
    parameter int AW      = 3,
    parameter int TMO_CYC = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    i_load_byte,
    input  logic          i_load_valid,
    output logic          o_load_ready,
    input  logic          i_clear,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_done,
    output logic [15:0]   o_inst_out,
    output logic          o_inst_valid,
    input  logic          i_inst_ready,
    input  logic [7:0]    i_res_in,
    input  logic          i_res_zero,
    input  logic          i_res_valid,
    output logic [7:0]    o_last_result,
    output logic [AW:0]   o_zero_count,
    output logic [AW:0]   o_prog_len,
    output logic          o_err
);

    localparam int          DEPTH   = 2 ** AW;
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t         r_state;
    logic [15:0]    r_mem [DEPTH];
    logic [7:0]     r_stage;
    logic           r_tog;
    logic [AW-1:0]  r_wr_ptr;
    logic [AW:0]    r_prog_len;
    logic [AW-1:0]  r_pc;
    logic [AW:0]    r_zero_count;
    logic [7:0]     r_last_result;
    logic           r_err;
    logic           r_done;
    logic           r_busy;
    logic           r_inst_valid;
    logic [15:0]    r_inst_out;
    logic           r_armed;

`ifdef ISSUER_TIMEOUT_EN
    localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    logic [TW-1:0]  r_tmo;
`endif

    logic           w_accept;
    logic           w_wr_en;
    logic           w_last;
    logic [AW-1:0]  w_pc_next;

    // r_armed keeps load_ready low while in reset and for the first cycle after release
    assign o_load_ready = r_armed & (r_state == S_IDLE) & ~i_start & (r_prog_len != DEPTH_L);
    assign w_accept     = i_load_valid & o_load_ready;
    assign w_wr_en      = w_accept & ~i_clear & r_tog;
    assign w_last       = ({1'b0, r_pc} == (r_prog_len - 1'b1));
    assign w_pc_next    = r_pc + 1'b1;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= {i_load_byte, r_stage};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_stage       <= '0;
            r_tog         <= 1'b0;
            r_wr_ptr      <= '0;
            r_prog_len    <= '0;
            r_pc          <= '0;
            r_zero_count  <= '0;
            r_last_result <= '0;
            r_err         <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
            r_inst_valid  <= 1'b0;
            r_inst_out    <= '0;
            r_armed       <= 1'b0;
`ifdef ISSUER_TIMEOUT_EN
            r_tmo         <= '0;
`endif
        end else begin
            r_armed <= 1'b1;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_tog <= 1'b0;
                        if (r_tog) begin
                            r_err <= 1'b1;
                        end
                        if (r_prog_len == '0) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_pc         <= '0;
                            r_zero_count <= '0;
                            r_inst_out   <= r_mem[0];
                            r_inst_valid <= 1'b1;
                            r_busy       <= 1'b1;
                            r_state      <= S_ISSUE;
                        end
                    end else if (i_clear) begin
                        r_prog_len <= '0;
                        r_wr_ptr   <= '0;
                        r_tog      <= 1'b0;
                        r_err      <= 1'b0;
                    end else if (w_accept) begin
                        if (!r_tog) begin
                            r_stage <= i_load_byte;
                            r_tog   <= 1'b1;
                        end else begin
                            r_wr_ptr   <= r_wr_ptr + 1'b1;
                            r_prog_len <= r_prog_len + 1'b1;
                            r_tog      <= 1'b0;
                        end
                    end
                end
                S_ISSUE: begin
                    if (i_inst_ready) begin
                        r_inst_valid <= 1'b0;
                        r_state      <= S_WAIT;
`ifdef ISSUER_TIMEOUT_EN
                        r_tmo        <= TW'(TMO_CYC - 1);
`endif
                    end
                end
                S_WAIT: begin
                    if (i_res_valid) begin
                        r_last_result <= i_res_in;
                        if (i_res_zero && (r_zero_count != DEPTH_L)) begin
                            r_zero_count <= r_zero_count + 1'b1;
                        end
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_pc         <= w_pc_next;
                            r_inst_out   <= r_mem[w_pc_next];
                            r_inst_valid <= 1'b1;
                            r_state      <= S_ISSUE;
                        end
                    end
`ifdef ISSUER_TIMEOUT_EN
                    else if (r_tmo == '0) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo - 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_inst_out    = r_inst_out;
    assign o_inst_valid  = r_inst_valid;
    assign o_last_result = r_last_result;
    assign o_zero_count  = r_zero_count;
    assign o_prog_len    = r_prog_len;
    assign o_err         = r_err;

endmodule

// File: tb/tb_inst_issuer.sv
// Bench for inst_issuer: table-driven program run, scoreboard of issued instructions, corner sequences.
module tb_inst_issuer;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int TMO   = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    i_load_byte = '0;
    logic          i_load_valid = 1'b0;
    logic          o_load_ready;
    logic          i_clear = 1'b0;
    logic          i_start = 1'b0;
    logic          o_busy;
    logic          o_done;
    logic [15:0]   o_inst_out;
    logic          o_inst_valid;
    logic          i_inst_ready = 1'b0;
    logic [7:0]    i_res_in = '0;
    logic          i_res_zero = 1'b0;
    logic          i_res_valid = 1'b0;
    logic [7:0]    o_last_result;
    logic [AW:0]   o_zero_count;
    logic [AW:0]   o_prog_len;
    logic          o_err;

    inst_issuer #(.AW(AW), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_load_byte(i_load_byte), .i_load_valid(i_load_valid), .o_load_ready(o_load_ready),
        .i_clear(i_clear), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
        .o_inst_out(o_inst_out), .o_inst_valid(o_inst_valid), .i_inst_ready(i_inst_ready),
        .i_res_in(i_res_in), .i_res_zero(i_res_zero), .i_res_valid(i_res_valid),
        .o_last_result(o_last_result), .o_zero_count(o_zero_count),
        .o_prog_len(o_prog_len), .o_err(o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] inst;
        logic [7:0]  res;
        logic        zero;
        int          rdy_dly;
        int          res_dly;
        logic [3:0]  exp_zc;
    } vec_t;

    vec_t        tab [8];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_hs = 0;
    int          n_done = 0;
    logic [15:0] exp_q [$];
    logic [15:0] m_prog [$];
    logic [7:0]  m_stage = '0;
    logic        m_tog = 1'b0;
    logic        m_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && o_inst_valid && i_inst_ready) begin
            n_hs++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL issue_unexpected: actual=%0h required=none", o_inst_out);
            end else begin
                check("issue_order", o_inst_out, exp_q.pop_front());
            end
        end
        if (rst_n && o_done) n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_b(input logic [7:0] b);
        i_load_byte  = b;
        i_load_valid = 1'b1;
        tick();
        i_load_valid = 1'b0;
        if (m_prog.size() != DEPTH) begin
            if (!m_tog) begin
                m_stage = b;
                m_tog   = 1'b1;
            end else begin
                m_prog.push_back({b, m_stage});
                m_tog = 1'b0;
            end
        end
    endtask

    task automatic start_run();
        i_start = 1'b1;
        if (m_tog) begin
            m_tog = 1'b0;
            m_err = 1'b1;
        end
        foreach (m_prog[i]) exp_q.push_back(m_prog[i]);
        tick();
        i_start = 1'b0;
    endtask

    task automatic clear_buf();
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        m_prog.delete();
        m_tog = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!o_inst_valid && t < 40) begin
            tick();
            t++;
        end
        if (!o_inst_valid) begin
            n_checks++;
            n_errors++;
            $display("FAIL inst_valid_wait: actual=0 required=1");
        end
    endtask

    task automatic handshake(input int rdy_dly);
        wait_valid();
        repeat (rdy_dly) tick();
        i_inst_ready = 1'b1;
        tick();
        i_inst_ready = 1'b0;
    endtask

    task automatic serve(input int rdy_dly, input int res_dly, input logic [7:0] r, input logic z);
        handshake(rdy_dly);
        repeat (res_dly - 1) tick();
        i_res_in    = r;
        i_res_zero  = z;
        i_res_valid = 1'b1;
        tick();
        i_res_valid = 1'b0;
        i_res_zero  = 1'b0;
        i_res_in    = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_inst_out"},  o_inst_out, 0);
        check({tag, "_inst_valid"}, o_inst_valid, 0);
        check({tag, "_busy"},      o_busy, 0);
        check({tag, "_done"},      o_done, 0);
        check({tag, "_last"},      o_last_result, 0);
        check({tag, "_zc"},        o_zero_count, 0);
        check({tag, "_len"},       o_prog_len, 0);
        check({tag, "_err"},       o_err, 0);
        check({tag, "_ld_rdy"},    o_load_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        int t;
        tab[0] = '{16'h8533, 8'h03, 1'b0, 0, 1, 4'd0};
        tab[1] = '{16'h2A11, 8'h00, 1'b1, 2, 1, 4'd1};
        tab[2] = '{16'h1C0A, 8'h7F, 1'b0, 0, 3, 4'd1};
        tab[3] = '{16'hF0F0, 8'h10, 1'b0, 1, 2, 4'd1};
        tab[4] = '{16'h0001, 8'h00, 1'b1, 3, 1, 4'd2};
        tab[5] = '{16'hBEEF, 8'hA5, 1'b0, 0, 2, 4'd2};
        tab[6] = '{16'h4242, 8'h5A, 1'b0, 1, 1, 4'd2};
        tab[7] = '{16'h7C3D, 8'hC9, 1'b0, 0, 4, 4'd2};

        // reset state
        #12;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // single ADD instruction
        load_b(8'h33);
        load_b(8'h85);
        check("t1_prog_len", o_prog_len, 1);
        start_run();
        check("t1_inst_valid", o_inst_valid, 1);
        check("t1_inst_out", o_inst_out, 16'h8533);
        check("t1_busy", o_busy, 1);
        serve(1, 2, 8'h03, 1'b0);
        check("t1_done", o_done, 1);
        check("t1_last", o_last_result, 8'h03);
        check("t1_zc", o_zero_count, 0);
        check("t1_busy_low", o_busy, 0);
        tick();
        check("t1_done_pulse", o_done, 0);
        check("t1_done_count", n_done, 1);

        // full buffer, table-driven run
        clear_buf();
        for (int i = 0; i < 8; i++) begin
            logic [15:0] w;
            w = tab[i].inst;
            load_b(w[7:0]);
            load_b(w[15:8]);
        end
        check("t2_prog_len", o_prog_len, DEPTH);
        i_load_byte  = 8'hAA;
        i_load_valid = 1'b1;
        #1;
        check("t2_full_ld_rdy", o_load_ready, 0);
        load_b(8'hAA);
        check("t2_prog_len_after17", o_prog_len, DEPTH);
        check("t2_err", o_err, 0);
        hs0 = n_hs;
        start_run();
        for (int i = 0; i < 8; i++) begin
            serve(tab[i].rdy_dly, tab[i].res_dly, tab[i].res, tab[i].zero);
            check("t2_last", o_last_result, tab[i].res);
            check("t2_zc", o_zero_count, tab[i].exp_zc);
        end
        check("t2_done", o_done, 1);
        check("t2_hs_count", n_hs - hs0, 8);
        tick();
        check("t2_done_count", n_done, 2);

        // ready held low in ISSUE, res_valid ignored there
        start_run();
        check("t4_valid0", o_inst_valid, 1);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                i_res_in    = 8'hEE;
                i_res_zero  = 1'b1;
                i_res_valid = 1'b1;
            end
            tick();
            i_res_valid = 1'b0;
            i_res_zero  = 1'b0;
            i_res_in    = '0;
            check("t4_valid_hold", o_inst_valid, 1);
            check("t4_inst_hold", o_inst_out, tab[0].inst);
            check("t4_last_hold", o_last_result, tab[7].res);
        end
        check("t4_zc_ignored", o_zero_count, 0);
        serve(0, 1, tab[0].res, tab[0].zero);
        serve(0, 1, tab[1].res, tab[1].zero);

        // reset during WAIT of instruction 3
        handshake(0);
        check("t5_busy_in_wait", o_busy, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("t5_rst");
        exp_q.delete();
        m_prog.delete();
        m_tog = 1'b0;
        m_err = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        hs0 = n_hs;
        start_run();
        check("t5_empty_done", o_done, 1);
        check("t5_empty_valid", o_inst_valid, 0);
        tick();
        check("t5_no_issue", n_hs - hs0, 0);

        // dangling byte on start, then clear
        load_b(8'h11);
        load_b(8'h22);
        load_b(8'h44);
        hs0 = n_hs;
        start_run();
        check("t3_err", o_err, m_err);
        check("t3_prog_len", o_prog_len, 1);
        serve(0, 1, 8'h00, 1'b1);
        check("t3_done", o_done, 1);
        check("t3_zc", o_zero_count, 1);
        check("t3_hs", n_hs - hs0, 1);
        tick();
        clear_buf();
        check("t3_err_clr", o_err, 0);
        check("t3_len_clr", o_prog_len, 0);
        start_run();
        check("t3_empty_done", o_done, 1);
        check("t3_empty_valid", o_inst_valid, 0);
        tick();

        // result withheld in WAIT
        load_b(8'h01);
        load_b(8'h02);
        start_run();
        handshake(0);
`ifdef ISSUER_TIMEOUT_EN
        t = 0;
        while (!o_done && t < 40) begin
            tick();
            t++;
        end
        check("t6_tmo_cycles", t, TMO);
        check("t6_tmo_err", o_err, 1);
        check("t6_tmo_last", o_last_result, 8'h00);
        check("t6_tmo_zc", o_zero_count, 0);
        tick();
        check("t6_tmo_idle_busy", o_busy, 0);
`else
        t = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (o_busy && !o_done) t++;
        end
        check("t6_busy_held", t, 100);
        check("t6_err", o_err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
